// File: rtl/calc_audio_pkg.sv
// Shared types and word vocabulary for the talking-calculator audio path.
// Word indices map 1:1 onto flash clips through phrase_addr_rom.
package calc_audio_pkg;

    typedef logic [4:0]  word_idx_t;
    typedef logic [23:0] flash_addr_t;

    localparam int NUM_WORDS = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOOKUP,
        S_LAUNCH,
        S_PLAY,
        S_GAP,
        S_NEXT
    } seq_state_t;

    localparam word_idx_t W_ZERO     = 5'd0;
    localparam word_idx_t W_ONE      = 5'd1;
    localparam word_idx_t W_TWO      = 5'd2;
    localparam word_idx_t W_THREE    = 5'd3;
    localparam word_idx_t W_FOUR     = 5'd4;
    localparam word_idx_t W_FIVE     = 5'd5;
    localparam word_idx_t W_SIX      = 5'd6;
    localparam word_idx_t W_SEVEN    = 5'd7;
    localparam word_idx_t W_EIGHT    = 5'd8;
    localparam word_idx_t W_NINE     = 5'd9;
    localparam word_idx_t W_PLUS     = 5'd10;
    localparam word_idx_t W_MINUS    = 5'd11;
    localparam word_idx_t W_TIMES    = 5'd12;
    localparam word_idx_t W_DIVIDE   = 5'd13;
    localparam word_idx_t W_EQUALS   = 5'd14;
    localparam word_idx_t W_POINT    = 5'd15;
    localparam word_idx_t W_ERROR    = 5'd16;
    localparam word_idx_t W_HUNDRED  = 5'd17;
    localparam word_idx_t W_THOUSAND = 5'd18;
    localparam word_idx_t W_MILLION  = 5'd19;
    localparam word_idx_t W_NEGATIVE = 5'd20;
    localparam word_idx_t W_CLEAR    = 5'd21;
    localparam word_idx_t W_MEMORY   = 5'd22;
    localparam word_idx_t W_PERCENT  = 5'd23;

endpackage

// File: rtl/phrase_addr_rom.sv
// Word index -> flash clip window {first byte, last byte}; one-cycle registered read.
// Clips sit on 32 KiB slots starting at 0x010000; unknown indices read as zero.
module phrase_addr_rom
    import calc_audio_pkg::*;
(
    input  logic        clk,
    input  word_idx_t   idx,
    output flash_addr_t start_addr,
    output flash_addr_t end_addr
);

    flash_addr_t start_next;
    flash_addr_t end_next;

    always_comb begin
        start_next = '0;
        end_next   = '0;
        case (idx)
            W_ZERO:     {start_next, end_next} = {24'h010000, 24'h012FFF};
            W_ONE:      {start_next, end_next} = {24'h018000, 24'h01B0FF};
            W_TWO:      {start_next, end_next} = {24'h020000, 24'h0231FF};
            W_THREE:    {start_next, end_next} = {24'h028000, 24'h02B2FF};
            W_FOUR:     {start_next, end_next} = {24'h030000, 24'h0333FF};
            W_FIVE:     {start_next, end_next} = {24'h038000, 24'h03B4FF};
            W_SIX:      {start_next, end_next} = {24'h040000, 24'h0435FF};
            W_SEVEN:    {start_next, end_next} = {24'h048000, 24'h04B6FF};
            W_EIGHT:    {start_next, end_next} = {24'h050000, 24'h0537FF};
            W_NINE:     {start_next, end_next} = {24'h058000, 24'h05B8FF};
            W_PLUS:     {start_next, end_next} = {24'h060000, 24'h0639FF};
            W_MINUS:    {start_next, end_next} = {24'h068000, 24'h06BAFF};
            W_TIMES:    {start_next, end_next} = {24'h070000, 24'h073BFF};
            W_DIVIDE:   {start_next, end_next} = {24'h078000, 24'h07BCFF};
            W_EQUALS:   {start_next, end_next} = {24'h080000, 24'h083DFF};
            W_POINT:    {start_next, end_next} = {24'h088000, 24'h08BEFF};
            W_ERROR:    {start_next, end_next} = {24'h090000, 24'h093FFF};
            W_HUNDRED:  {start_next, end_next} = {24'h098000, 24'h09C0FF};
            W_THOUSAND: {start_next, end_next} = {24'h0A0000, 24'h0A41FF};
            W_MILLION:  {start_next, end_next} = {24'h0A8000, 24'h0AC2FF};
            W_NEGATIVE: {start_next, end_next} = {24'h0B0000, 24'h0B43FF};
            W_CLEAR:    {start_next, end_next} = {24'h0B8000, 24'h0BC4FF};
            W_MEMORY:   {start_next, end_next} = {24'h0C0000, 24'h0C45FF};
            W_PERCENT:  {start_next, end_next} = {24'h0C8000, 24'h0CC6FF};
            default:    {start_next, end_next} = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        start_addr <= start_next;
        end_addr   <= end_next;
    end

endmodule

// File: rtl/phrase_sequencer.sv
// Buffers spoken-word indices and launches the flash playback engine once per word,
// with a fixed silence gap after each word and a phrase_done pulse at the end.
module phrase_sequencer
    import calc_audio_pkg::*;
#(
    parameter int QUEUE_DEPTH = 16,
    parameter int WORD_W      = 5,
    parameter int NUM_WORDS   = calc_audio_pkg::NUM_WORDS,
    parameter int ADDR_W      = 24,
    parameter int GAP_CYCLES  = 500000
) (
    input  logic              clk50M,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    input  logic              speak,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              phrase_done,
    output logic              overflow,
    output logic              bad_word,
    output logic              play_start,
    output logic [ADDR_W-1:0] play_start_addr,
    output logic [ADDR_W-1:0] play_end_addr,
    input  logic              play_done,
    output logic              silent
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam word_idx_t        LAST_WORD = word_idx_t'(NUM_WORDS - 1);

    logic [WORD_W-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg, bad_word_reg;
    logic              pop, wr_en;

    seq_state_t        state_reg, state_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic              latch_addr, set_bad;
    word_idx_t         fetch_idx_reg;
    flash_addr_t       rom_start, rom_end;
    logic [ADDR_W-1:0] start_addr_reg, end_addr_reg;

    assign full     = (count_reg == DEPTH_CNT);
    assign empty    = (count_reg == '0);
    assign overflow = overflow_reg;
    assign bad_word = bad_word_reg;
    assign busy     = (state_reg != S_IDLE);
    assign silent   = !((state_reg == S_LAUNCH) || (state_reg == S_PLAY));
    assign play_start_addr = start_addr_reg;
    assign play_end_addr   = end_addr_reg;

    // A pop frees a slot in the same cycle, so a full queue still accepts that push.
    assign pop   = (state_reg == S_FETCH) && !empty;
    assign wr_en = push && !flush && (!full || pop);

    always_ff @(posedge clk50M) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk50M) begin
        if (reset || flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop) overflow_reg <= 1'b1;
        end
    end

    phrase_addr_rom u_rom (
        .clk        (clk50M),
        .idx        (word_idx_t'(mem[rd_ptr_reg])),
        .start_addr (rom_start),
        .end_addr   (rom_end)
    );

    // Tracks the index the ROM is looking up so LOOKUP can reject out-of-range words.
    always_ff @(posedge clk50M) begin
        fetch_idx_reg <= word_idx_t'(mem[rd_ptr_reg]);
    end

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = '0;
        play_start   = 1'b0;
        phrase_done  = 1'b0;
        latch_addr   = 1'b0;
        set_bad      = 1'b0;
        case (state_reg)
            S_IDLE:   if (speak && !empty) state_next = S_FETCH;
            S_FETCH:  state_next = empty ? S_NEXT : S_LOOKUP;
            S_LOOKUP: begin
                if (fetch_idx_reg > LAST_WORD) begin
                    set_bad    = 1'b1;
                    state_next = S_NEXT;
                end else begin
                    latch_addr = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                play_start = 1'b1;
                state_next = S_PLAY;
            end
            S_PLAY:   if (play_done) state_next = S_GAP;
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) state_next = S_NEXT;
                else                         gap_cnt_next = gap_cnt_reg + 1'b1;
            end
            S_NEXT: begin
                if (!empty) begin
                    state_next = S_FETCH;
                end else begin
                    state_next  = S_IDLE;
                    phrase_done = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            gap_cnt_reg    <= '0;
            bad_word_reg   <= 1'b0;
            start_addr_reg <= '0;
            end_addr_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            if (set_bad) bad_word_reg <= 1'b1;
            if (latch_addr) begin
                start_addr_reg <= rom_start;
                end_addr_reg   <= rom_end;
            end
        end
    end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Randomized scoreboard bench for phrase_sequencer with an 8-cycle gap and a model
// playback engine; expected launches come from a word-queue model and a clip-slot formula.
module tb_phrase_sequencer;

    localparam int GAP   = 8;
    localparam int DEPTH = 16;

    logic        clk50M = 1'b0;
    logic        reset = 1'b1, push = 1'b0, speak = 1'b0, flush = 1'b0, play_done = 1'b0;
    logic [4:0]  push_word = '0;
    logic        full, empty, busy, phrase_done, overflow, bad_word, play_start, silent;
    logic [23:0] play_start_addr, play_end_addr;

    phrase_sequencer #(
        .QUEUE_DEPTH (DEPTH),
        .WORD_W      (5),
        .NUM_WORDS   (24),
        .ADDR_W      (24),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk50M          (clk50M),
        .reset           (reset),
        .push            (push),
        .push_word       (push_word),
        .speak           (speak),
        .flush           (flush),
        .full            (full),
        .empty           (empty),
        .busy            (busy),
        .phrase_done     (phrase_done),
        .overflow        (overflow),
        .bad_word        (bad_word),
        .play_start      (play_start),
        .play_start_addr (play_start_addr),
        .play_end_addr   (play_end_addr),
        .play_done       (play_done),
        .silent          (silent)
    );

    always #10 clk50M = ~clk50M;

    typedef struct {
        int          w;
        logic [23:0] s;
        logic [23:0] e;
    } launch_t;

    launch_t exp_q[$];
    int      mq[$];
    int      tests = 0, fails = 0;
    int      exp_done = 0;
    int      cyc = 0, speak_cyc = 0, silent_run = 0, eng_delay = 0;
    bit      in_phrase = 0, first_launch = 0, exp_overflow = 0, exp_bad = 0;

    always @(posedge clk50M) cyc <= cyc + 1;

    // Clip layout: 32 KiB slots from 0x010000, clip length 0x3000 + 0x100 per index.
    function automatic logic [23:0] exp_start(int w);
        return 24'(32'h010000 + w * 32'h8000);
    endfunction

    function automatic logic [23:0] exp_end(int w);
        return 24'(32'h010000 + w * 32'h8000 + 32'h2FFF + w * 32'h100);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_expect(int w);
        launch_t l;
        if (w < 24) begin
            l.w = w; l.s = exp_start(w); l.e = exp_end(w);
            exp_q.push_back(l);
        end else begin
            exp_bad = 1;
        end
    endtask

    task automatic do_push(int w);
        push      = 1'b1;
        push_word = w[4:0];
        if (in_phrase)              add_expect(w);
        else if (mq.size() < DEPTH) mq.push_back(w);
        else                        exp_overflow = 1;
        $display("[TB] push word %0d", w);
        @(negedge clk50M);
        push = 1'b0;
    endtask

    task automatic do_speak();
        speak     = 1'b1;
        speak_cyc = cyc;
        if (mq.size() > 0) begin
            foreach (mq[i]) add_expect(mq[i]);
            mq.delete();
            exp_done++;
            in_phrase    = 1;
            first_launch = 1;
        end
        $display("[TB] speak");
        @(negedge clk50M);
        speak = 1'b0;
    endtask

    task automatic wait_phrase(string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk50M);
            n++;
        end
        if (busy) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles expected idle", name, n);
        end
        in_phrase = 0;
        check({name, "_empty"}, empty, 1'b1);
        check({name, "_pending_launches"}, exp_q.size(), 0);
        check({name, "_pending_done"}, exp_done, 0);
    endtask

    task automatic wait_launch(string name);
        int n = 0;
        while (!play_start && n < 200) begin
            @(negedge clk50M);
            n++;
        end
        if (!play_start) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no play_start expected one", name);
        end
        @(negedge clk50M);
    endtask

    // Monitor: scoreboard for play_start / phrase_done plus silence-gap length.
    initial begin
        launch_t e;
        forever begin
            @(negedge clk50M);
            if (reset) begin
                silent_run = 0;
            end else begin
                if (silent) silent_run++;
                else        silent_run = 0;
                if (play_start) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_play_start: got start=%h expected none", play_start_addr);
                    end else begin
                        e = exp_q.pop_front();
                        $display("[TB] launch word %0d start=%h end=%h", e.w, play_start_addr, play_end_addr);
                        check("play_start_addr", play_start_addr, e.s);
                        check("play_end_addr", play_end_addr, e.e);
                        check("silent_in_launch", silent, 1'b0);
                        if (first_launch) begin
                            check("speak_latency", cyc - speak_cyc, 3);
                            first_launch = 0;
                        end
                    end
                end
                if (phrase_done) begin
                    $display("[TB] phrase_done");
                    if (exp_done == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_phrase_done: got pulse expected none");
                    end else begin
                        exp_done--;
                        check("gap_silence_cycles", silent_run, GAP + 1);
                    end
                end
            end
        end
    end

    // Playback engine model: finishes each word 1..6 cycles after launch.
    initial begin
        forever begin
            @(negedge clk50M);
            if (play_start && !reset) begin
                eng_delay = $urandom_range(1, 6);
                repeat (eng_delay) @(negedge clk50M);
                play_done = 1'b1;
                @(negedge clk50M);
                play_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        repeat (3) @(negedge clk50M);
        check("rst_busy", busy, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_silent", silent, 1'b1);
        check("rst_overflow", overflow, 1'b0);
        check("rst_bad_word", bad_word, 1'b0);
        check("rst_play_start", play_start, 1'b0);
        check("rst_phrase_done", phrase_done, 1'b0);
        check("rst_start_addr", play_start_addr, 24'h0);
        check("rst_end_addr", play_end_addr, 24'h0);
        reset = 1'b0;
        @(negedge clk50M);

        // Basic phrase 3,1,4
        do_push(3); do_push(1); do_push(4);
        check("empty_after_push", empty, 1'b0);
        do_speak();
        wait_phrase("basic");

        // Overflow: 17 pushes into 16 slots
        for (int i = 0; i < 17; i++) begin
            do_push($urandom_range(0, 23));
            if (i == 14) check("not_full_at_15", full, 1'b0);
            if (i == 15) check("full_at_16", full, 1'b1);
        end
        check("overflow_set", overflow, exp_overflow);
        do_speak();
        wait_phrase("overflow");
        check("overflow_sticky", overflow, exp_overflow);

        // Full queue: push in the same cycle as the FETCH pop
        for (int i = 0; i < 16; i++) do_push($urandom_range(0, 23));
        do_speak();
        do_push($urandom_range(0, 23));
        check("full_push_pop", full, 1'b1);
        check("overflow_unchanged", overflow, exp_overflow);
        wait_phrase("push_pop");
        check("bad_word_clear", bad_word, exp_bad);

        // Invalid index is skipped and flagged
        do_push(2); do_push(31); do_push(5);
        do_speak();
        wait_phrase("bad_word");
        check("bad_word_set", bad_word, exp_bad);

        // Random short phrases
        for (int p = 0; p < 3; p++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) do_push($urandom_range(0, 23));
            do_speak();
            wait_phrase("random");
        end

        // Flush during the first of four words
        for (int i = 0; i < 4; i++) do_push($urandom_range(0, 23));
        do_speak();
        wait_launch("flush");
        exp_q.delete();
        exp_overflow = 0;
        flush = 1'b1;
        $display("[TB] flush");
        @(negedge clk50M);
        flush = 1'b0;
        check("flush_empty", empty, 1'b1);
        check("flush_overflow_clear", overflow, exp_overflow);
        check("flush_still_busy", busy, 1'b1);
        wait_phrase("flush");

        // Reset while playing
        do_push(7); do_push(9);
        do_speak();
        wait_launch("reset");
        reset = 1'b1;
        $display("[TB] reset in PLAY");
        @(negedge clk50M);
        exp_q.delete();
        exp_done = 0; in_phrase = 0; first_launch = 0; exp_bad = 0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_silent", silent, 1'b1);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_bad_word", bad_word, exp_bad);
        reset = 1'b0;
        @(negedge clk50M);
        do_speak();
        repeat (10) @(negedge clk50M);
        check("speak_empty_idle", busy, 1'b0);

        w = exp_q.size();
        check("final_pending_launches", w, 0);
        check("final_pending_done", exp_done, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
